// File: rtl/multichannel_filter_if.sv
// multichannel_filter_if: raw inputs and filtered levels/events shared between the pin side and downstream logic
interface multichannel_filter_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] sig_in;
    logic                bypass_in;
    logic [CHANNELS-1:0] sig_out;
    logic [CHANNELS-1:0] rise_out;
    logic [CHANNELS-1:0] fall_out;
    logic [CHANNELS-1:0] glitch_out;

    modport master (
        output sig_in, bypass_in,
        input  sig_out, rise_out, fall_out, glitch_out
    );

    modport slave (
        input  sig_in, bypass_in,
        output sig_out, rise_out, fall_out, glitch_out
    );
endinterface

// File: rtl/multichannel_filter.sv
// multichannel_filter: per-channel synchroniser plus rise/fall qualification filter with edge and glitch pulses
module multichannel_filter #(
    parameter int                  CHANNELS    = 4,
    parameter int                  RISE_LEN    = 100,
    parameter int                  FALL_LEN    = 100,
    parameter int                  CNT_WIDTH   = 16,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
    input logic                  clk_50mhz_in,
    input logic                  reset_in,
    multichannel_filter_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] RISE_LAST = CNT_WIDTH'(RISE_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] FALL_LAST = CNT_WIDTH'(FALL_LEN - 1);

    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]  s, differ, fire;
    logic [CHANNELS-1:0]  out_q, out_d;
    logic [CHANNELS-1:0]  rise_q, rise_d, fall_q, fall_d, glitch_q, glitch_d;

    assign s = sync_q[SYNC_STAGES-1];

    // fire means sig_out takes s this edge; in bypass that is any difference at all
    always_comb begin
        differ   = s ^ out_q;
        fire     = '0;
        glitch_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            fire[c]     = differ[c] && (bus.bypass_in || cnt_q[c] == (out_q[c] ? FALL_LAST : RISE_LAST));
            cnt_d[c]    = (bus.bypass_in || !differ[c] || fire[c]) ? '0 : cnt_q[c] + 1'b1;
            glitch_d[c] = !bus.bypass_in && !differ[c] && cnt_q[c] != '0;
        end
        out_d  = out_q ^ fire;
        rise_d = fire & s;
        fall_d = fire & ~s;
    end

    always_ff @(posedge clk_50mhz_in) begin
        if (reset_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VALUE;
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
            out_q    <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
            glitch_q <= '0;
        end else begin
            sync_q[0] <= bus.sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign bus.sig_out    = out_q;
    assign bus.rise_out   = rise_q;
    assign bus.fall_out   = fall_q;
    assign bus.glitch_out = glitch_q;
endmodule

// File: tb/tb_multichannel_filter.sv
// tb_multichannel_filter: vector table on a short-length instance plus timing sequences on default and 10/50 instances
module tb_multichannel_filter;
    logic clk_50mhz_in = 1'b0;
    logic rst_a, rst_bc;
    int   total = 0;
    int   bad   = 0;

    always #10 clk_50mhz_in = ~clk_50mhz_in;

    multichannel_filter_if #(.CHANNELS(4)) ia ();
    multichannel_filter_if #(.CHANNELS(4)) ib ();
    multichannel_filter_if #(.CHANNELS(2)) ic ();

    multichannel_filter #(.RESET_VALUE(4'b0101)) u_a (
        .clk_50mhz_in(clk_50mhz_in), .reset_in(rst_a), .bus(ia)
    );
    multichannel_filter #(.RISE_LEN(10), .FALL_LEN(50)) u_b (
        .clk_50mhz_in(clk_50mhz_in), .reset_in(rst_bc), .bus(ib)
    );
    multichannel_filter #(.CHANNELS(2), .RISE_LEN(2), .FALL_LEN(3), .CNT_WIDTH(4), .SYNC_STAGES(1)) u_c (
        .clk_50mhz_in(clk_50mhz_in), .reset_in(rst_bc), .bus(ic)
    );

    typedef struct {
        logic [1:0] in;
        logic       byp;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50mhz_in);
        #1;
    endtask

    initial begin
        int n, errs, gl, highs, rise_at, fall_at, e_out, e_edge, e_gl;
        logic [3:0] rv, h;
        // {sig_in, bypass, {sig_out, rise, fall, glitch}} with RISE_LEN=2, FALL_LEN=3, one sync stage
        tbl = '{
            '{2'b01, 1'b0, 8'b00_00_00_00}, '{2'b01, 1'b0, 8'b00_00_00_00},
            '{2'b01, 1'b0, 8'b01_01_00_00}, '{2'b00, 1'b0, 8'b01_00_00_00},
            '{2'b00, 1'b0, 8'b01_00_00_00}, '{2'b01, 1'b0, 8'b01_00_00_00},
            '{2'b01, 1'b0, 8'b01_00_00_01}, '{2'b00, 1'b0, 8'b01_00_00_00},
            '{2'b00, 1'b0, 8'b01_00_00_00}, '{2'b00, 1'b0, 8'b01_00_00_00},
            '{2'b00, 1'b0, 8'b00_00_01_00}, '{2'b11, 1'b0, 8'b00_00_00_00},
            '{2'b11, 1'b0, 8'b00_00_00_00}, '{2'b11, 1'b0, 8'b11_11_00_00},
            '{2'b00, 1'b1, 8'b11_00_00_00}, '{2'b00, 1'b1, 8'b00_00_11_00},
            '{2'b10, 1'b1, 8'b00_00_00_00}, '{2'b10, 1'b1, 8'b10_10_00_00},
            '{2'b10, 1'b0, 8'b10_00_00_00}, '{2'b11, 1'b0, 8'b10_00_00_00},
            '{2'b11, 1'b0, 8'b10_00_00_00}, '{2'b11, 1'b1, 8'b11_01_00_00},
            '{2'b11, 1'b0, 8'b11_00_00_00}, '{2'b01, 1'b0, 8'b11_00_00_00},
            '{2'b01, 1'b0, 8'b11_00_00_00}, '{2'b11, 1'b1, 8'b01_00_10_00},
            '{2'b11, 1'b0, 8'b01_00_00_00}, '{2'b11, 1'b0, 8'b11_10_00_00}
        };
        rst_a = 1'b1; rst_bc = 1'b1;
        ia.sig_in = 4'b0101; ia.bypass_in = 1'b0;
        ib.sig_in = 4'b0000; ib.bypass_in = 1'b0;
        ic.sig_in = 2'b00;   ic.bypass_in = 1'b0;
        repeat (3) tick();
        check("reset_a", {ia.sig_out, ia.rise_out, ia.fall_out, ia.glitch_out}, 16'h5000);
        check("reset_c", {ic.sig_out, ic.rise_out, ic.fall_out, ic.glitch_out}, 8'h00);
        rst_a = 1'b0; rst_bc = 1'b0;

        foreach (tbl[i]) begin
            ic.sig_in = tbl[i].in;
            ic.bypass_in = tbl[i].byp;
            tick();
            check($sformatf("vec%0d", i), {ic.sig_out, ic.rise_out, ic.fall_out, ic.glitch_out}, tbl[i].exp);
        end

        errs = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if ({ia.sig_out, ia.rise_out, ia.fall_out, ia.glitch_out} !== 16'h5000) errs++;
        end
        check("reset_hold", errs, 0);

        ia.sig_in[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ia.sig_out[1] && n < 300);
        check("rise_latency", n, 102);
        check("rise_pulse", ia.rise_out, 4'b0010);
        check("rise_others", ia.sig_out, 4'b0111);
        tick();
        check("rise_once", ia.rise_out, 4'b0000);

        gl = 0; errs = 0;
        for (int k = 0; k < 1010; k++) begin
            ia.sig_in[3] = k < 1000 && ((k / 5) % 2) == 1;
            tick();
            gl += int'(ia.glitch_out[3]);
            if (ia.sig_out[3] !== 1'b0 || ia.rise_out[3] !== 1'b0) errs++;
        end
        check("toggle_stable", errs, 0);
        check("toggle_glitches", gl, 100);

        gl = 0; highs = 0;
        for (int k = 1; k <= 40; k++) begin
            ib.sig_in[1] = k <= 9;
            tick();
            gl += int'(ib.glitch_out[1]);
            highs += int'(ib.sig_out[1]);
        end
        check("short_glitch", gl, 1);
        check("short_rejected", highs, 0);

        rise_at = 0; fall_at = 0; rv = '0;
        for (int k = 1; k <= 100; k++) begin
            ib.sig_in[1] = k <= 10;
            if (k == 1) begin ib.sig_in[0] = 1'b1; ib.sig_in[2] = 1'b1; end
            tick();
            if (ib.rise_out[1]) rise_at = k;
            if (ib.fall_out[1]) fall_at = k;
            if (k == 12) rv = ib.rise_out;
        end
        check("len_rise", rise_at, 12);
        check("len_fall", fall_at, 62);
        check("simul_rise", rv, 4'b0111);

        h = 4'b1111; e_out = 0; e_edge = 0; e_gl = 0;
        ia.bypass_in = 1'b1;
        for (int k = 0; k < 60; k++) begin
            ia.sig_in[2] = ((k / 3) % 2) == 1;
            h = {h[2:0], ia.sig_in[2]};
            tick();
            if (ia.sig_out[2] !== h[2]) e_out++;
            if (ia.rise_out[2] !== (h[2] & ~h[3]) || ia.fall_out[2] !== (~h[2] & h[3])) e_edge++;
            if (ia.glitch_out !== 4'b0000) e_gl++;
        end
        check("byp_follow", e_out, 0);
        check("byp_edges", e_edge, 0);
        check("byp_noglitch", e_gl, 0);
        ia.sig_in[2] = 1'b1;
        repeat (4) tick();
        ia.sig_in[2] = 1'b0;
        ia.bypass_in = 1'b0;
        n = 0;
        do begin tick(); n++; end while (ia.sig_out[2] && n < 300);
        check("byp_resume", n, 102);
        check("byp_resume_fall", ia.fall_out, 4'b0100);

        ia.sig_in[3] = 1'b1;
        repeat (62) tick();
        check("pend_rise", ia.sig_out[3], 1'b0);
        rst_a = 1'b1;
        tick();
        check("mid_reset", {ia.sig_out, ia.rise_out, ia.fall_out, ia.glitch_out}, 16'h5000);
        rst_a = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!ia.sig_out[3] && n < 300);
        check("fresh_rise", n, 102);
        check("fresh_pulse", ia.rise_out, 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
